// File: rtl/jtcontra_pkg.sv
// Shared definitions for the Contra video ROM slots: FSM encoding and
// per-game SDRAM base addresses for the object ROM region.
package jtcontra_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } obj_state_t;

  localparam logic [21:0] OBJ_OFFSET        = 22'h0;
  localparam logic [21:0] CONTRA_OBJ_OFFSET = 22'h10000;

endpackage

// File: rtl/jtcontra_obj_rom_slot.sv
// Object ROM responder for the 007121 sprite engine: serves 16-bit words
// out of a single 32-bit line refilled from SDRAM one even/odd pair at a time.
module jtcontra_obj_rom_slot
  import jtcontra_pkg::*;
#(
  parameter int              AW     = 18,
  parameter int              SDW    = 22,
  parameter logic [SDW-1:0]  OFFSET = SDW'(OBJ_OFFSET)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           downloading,
  input  logic           rom_cs,
  input  logic [AW-1:0]  rom_addr,
  output logic           rom_ok,
  output logic [15:0]    rom_data,
  output logic           sdram_req,
  output logic [SDW-1:0] sdram_addr,
  input  logic           sdram_ack,
  input  logic           data_rdy,
  input  logic [31:0]    sdram_din
);

  obj_state_t     state;
  logic [31:0]    line;
  logic [AW-2:0]  tag;
  logic [AW-2:0]  req_tag;
  logic           valid;
  logic           hit;
  logic [SDW-1:0] even_addr;

  assign hit       = valid & (tag == rom_addr[AW-1:1]);
  assign rom_ok    = rom_cs & hit & ~downloading;
  assign rom_data  = rom_addr[0] ? line[31:16] : line[15:0];
  assign even_addr = SDW'({rom_addr[AW-1:1], 1'b0});

  // A fill always lands in the line, even if the client moved on; valid is
  // withheld while a download may be rewriting the ROM underneath us.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      line       <= '0;
      tag        <= '0;
      req_tag    <= '0;
      valid      <= 1'b0;
    end else begin
      if (downloading) valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rom_cs && !hit && !downloading) begin
            req_tag    <= rom_addr[AW-1:1];
            sdram_addr <= OFFSET + even_addr;
            sdram_req  <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            if (data_rdy) begin
              line  <= sdram_din;
              tag   <= req_tag;
              valid <= ~downloading;
              state <= IDLE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (data_rdy) begin
            line  <= sdram_din;
            tag   <= req_tag;
            valid <= ~downloading;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
